// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle for dmem_port_arbiter: CPU MEM-stage side, DMA/loader side,
// data-memory/IO side and the stall performance counter.
// The slave modport is the arbiter's view; the master modport is the view of
// whatever drives the requesters and models the memory.
interface dmem_port_arbiter_if;
    // CPU MEM stage
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    // DMA / loader master
    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_last;
    logic        dma_gnt;
    logic [31:0] dma_rdata;
    logic        dma_err;
    logic        dma_err_clr;
    // Data memory / IO port
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;
    // Performance
    logic [15:0] perf_stall;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dma_req, dma_we, dma_addr, dma_wdata, dma_last, dma_err_clr,
        output dma_gnt, dma_rdata, dma_err,
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata,
        output perf_stall
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dma_req, dma_we, dma_addr, dma_wdata, dma_last, dma_err_clr,
        input  dma_gnt, dma_rdata, dma_err,
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata,
        input  perf_stall
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single data-memory/IO port between the CPU
// MEM stage (priority) and a burst DMA/loader master. DMA waiting behind the
// CPU is force-granted after MAX_WAIT cycles; a DMA grant is released after
// at most BURST_MAX beats, followed by one HOLD cycle back to the CPU.
// Optional feature macro: DMEM_ARB_PERF_EN builds the CPU stall-cycle counter
// on perf_stall; without it perf_stall is tied to zero.
module dmem_port_arbiter #(
    parameter int unsigned MAX_WAIT  = 8,   // 1..255
    parameter int unsigned BURST_MAX = 16   // 1..255
) (
    input  logic                   ram_clock,
    input  logic                   resetn,
    dmem_port_arbiter_if.slave     bus
);

    typedef enum logic [1:0] {
        ST_CPU  = 2'd0,
        ST_DMA  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);
    localparam logic [7:0] BEAT_LAST = 8'(BURST_MAX - 1);

    state_t      state_r;
    state_t      state_s;
    logic [7:0]  wait_cnt_r;
    logic [7:0]  wait_cnt_s;
    logic [7:0]  beat_cnt_r;
    logic [7:0]  beat_cnt_s;
    logic        dma_err_r;
    logic        dma_err_s;
    logic        io_hit_s;
    logic        dma_beat_s;
    logic        dma_owns_s;

    // The top 256 bytes of the address space are memory-mapped IO.
    assign io_hit_s   = (bus.dma_addr[31:8] == 24'hffffff);
    // Grant is decoded from registered state only, never from dma_req.
    assign dma_owns_s = (state_r == ST_DMA);
    assign dma_beat_s = dma_owns_s & bus.dma_req;

    // State, wait counter, beat counter and sticky error register.
    always_ff @(posedge ram_clock or negedge resetn) begin
        if (!resetn) begin
            state_r    <= ST_CPU;
            wait_cnt_r <= 8'd0;
            beat_cnt_r <= 8'd0;
            dma_err_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
            beat_cnt_r <= beat_cnt_s;
            dma_err_r  <= dma_err_s;
        end
    end

    // Next-state logic: CPU priority, bounded DMA wait and bounded burst.
    always_comb begin
        state_s    = state_r;
        wait_cnt_s = wait_cnt_r;
        beat_cnt_s = beat_cnt_r;
        case (state_r)
            ST_CPU: begin
                if (bus.dma_req && bus.cpu_req) begin
                    if (wait_cnt_r != 8'hff) begin
                        wait_cnt_s = wait_cnt_r + 8'd1;
                    end else begin
                        wait_cnt_s = wait_cnt_r;
                    end
                end else begin
                    wait_cnt_s = 8'd0;
                end
                if (bus.dma_req && (!bus.cpu_req || (wait_cnt_r == WAIT_LAST))) begin
                    state_s    = ST_DMA;
                    beat_cnt_s = 8'd0;
                    wait_cnt_s = 8'd0;
                end else begin
                    state_s = ST_CPU;
                end
            end
            ST_DMA: begin
                wait_cnt_s = 8'd0;
                if (bus.dma_req) begin
                    beat_cnt_s = beat_cnt_r + 8'd1;
                    if (bus.dma_last || (beat_cnt_r == BEAT_LAST)) begin
                        state_s = ST_HOLD;
                    end else begin
                        state_s = ST_DMA;
                    end
                end else begin
                    // Burst abandoned: hand the port back.
                    state_s = ST_HOLD;
                end
            end
            ST_HOLD: begin
                wait_cnt_s = 8'd0;
                state_s    = ST_CPU;
            end
            default: begin
                state_s    = ST_CPU;
                wait_cnt_s = 8'd0;
                beat_cnt_s = 8'd0;
            end
        endcase
    end

    // Sticky IO-write error; a new error in the clear cycle keeps it set.
    always_comb begin
        dma_err_s = dma_err_r;
        if (dma_beat_s && bus.dma_we && io_hit_s) begin
            dma_err_s = 1'b1;
        end else if (bus.dma_err_clr) begin
            dma_err_s = 1'b0;
        end else begin
            dma_err_s = dma_err_r;
        end
    end

    // Port mux: the owner selected by registered state drives the memory.
    always_comb begin
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
        bus.mem_we    = 1'b0;
        if (dma_owns_s) begin
            bus.mem_addr  = bus.dma_addr;
            bus.mem_wdata = bus.dma_wdata;
            bus.mem_we    = bus.dma_req & bus.dma_we & ~io_hit_s;
        end else begin
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
            bus.mem_we    = bus.cpu_req & bus.cpu_we;
        end
    end

    assign bus.cpu_rdata = bus.mem_rdata;
    assign bus.dma_rdata = bus.mem_rdata;
    assign bus.dma_gnt   = dma_owns_s;
    assign bus.cpu_stall = dma_owns_s & bus.cpu_req;
    assign bus.dma_err   = dma_err_r;

`ifdef DMEM_ARB_PERF_EN
    logic [15:0] perf_stall_r;

    // Saturating count of cycles in which the pipeline is held.
    always_ff @(posedge ram_clock or negedge resetn) begin
        if (!resetn) begin
            perf_stall_r <= 16'h0000;
        end else if (bus.cpu_stall && (perf_stall_r != 16'hffff)) begin
            perf_stall_r <= perf_stall_r + 16'h0001;
        end else begin
            perf_stall_r <= perf_stall_r;
        end
    end

    assign bus.perf_stall = perf_stall_r;
`else
    assign bus.perf_stall = 16'h0000;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed testbench for dmem_port_arbiter. Expected memory writes are queued
// when the stimulus drives them and popped when the port shows mem_we.
module tb_dmem_port_arbiter;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic ram_clock = 1'b0;
    logic resetn;
    int   checks   = 0;
    int   failures = 0;
    wr_t  exp_q[$];
    wr_t  got;
    int   b;
    int   exp_stall;
    logic exp_g;

    dmem_port_arbiter_if bus ();

    dmem_port_arbiter #(.MAX_WAIT(8), .BURST_MAX(16)) dut (
        .ram_clock (ram_clock),
        .resetn    (resetn),
        .bus       (bus.slave)
    );

    always #5 ram_clock = ~ram_clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    // Move to the falling edge and score any memory write seen there.
    task automatic settle();
        @(negedge ram_clock);
        if (bus.mem_we === 1'b1) begin
            chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                got = exp_q.pop_front();
                chk("write_addr_data", {bus.mem_addr, bus.mem_wdata}, {got.addr, got.data});
            end
        end
    endtask

    task automatic advance();
        @(posedge ram_clock);
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0; bus.cpu_wdata = 32'h0;
        bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = 32'h0; bus.dma_wdata = 32'h0;
        bus.dma_last = 1'b0; bus.dma_err_clr = 1'b0; bus.mem_rdata = 32'h5a5a_0010;
        exp_stall = 0;

        // Reset state
        repeat (2) advance();
        settle();
        chk("rst_gnt",   64'(bus.dma_gnt),    64'd0);
        chk("rst_stall", 64'(bus.cpu_stall),  64'd0);
        chk("rst_err",   64'(bus.dma_err),    64'd0);
        chk("rst_we",    64'(bus.mem_we),     64'd0);
        chk("rst_perf",  64'(bus.perf_stall), 64'd0);
        advance();
        resetn = 1'b1;

        // CPU loads with DMA idle, then one CPU store
        bus.cpu_req = 1'b1; bus.cpu_addr = 32'h10;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("cpu_ld_addr",  64'(bus.mem_addr),  64'h10);
            chk("cpu_ld_we",    64'(bus.mem_we),    64'd0);
            chk("cpu_ld_stall", 64'(bus.cpu_stall), 64'd0);
            chk("cpu_rdata",    64'(bus.cpu_rdata), 64'h5a5a_0010);
            advance();
        end
        bus.cpu_we = 1'b1; bus.cpu_addr = 32'h20; bus.cpu_wdata = 32'h1234_5678;
        push_wr(32'h20, 32'h1234_5678);
        settle();
        chk("cpu_st_we", 64'(bus.mem_we), 64'd1);
        advance();
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;

        // Three-beat DMA write burst with CPU idle
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 32'h0; bus.dma_wdata = 32'hd0;
        settle();
        chk("burst3_gnt_lat", 64'(bus.dma_gnt), 64'd0);
        advance();
        for (int k = 0; k < 3; k++) begin
            bus.dma_addr = 32'(4 * k); bus.dma_wdata = 32'hd0 + 32'(k); bus.dma_last = (k == 2);
            push_wr(32'(4 * k), 32'hd0 + 32'(k));
            settle();
            chk("burst3_gnt", 64'(bus.dma_gnt), 64'd1);
            advance();
        end
        bus.dma_req = 1'b0; bus.dma_last = 1'b0;
        settle();
        chk("burst3_hold_gnt", 64'(bus.dma_gnt), 64'd0);
        advance();
        settle();
        chk("burst3_cpu_gnt", 64'(bus.dma_gnt), 64'd0);
        advance();

        // Forced grant behind a continuous CPU stream
        bus.cpu_req = 1'b1; bus.cpu_addr = 32'h40; bus.cpu_we = 1'b0;
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 32'h100; bus.dma_last = 1'b1;
        bus.mem_rdata = 32'h0bad_f00d;
        for (int i = 0; i <= 8; i++) begin
            settle();
            chk("force_gnt",   64'(bus.dma_gnt),   64'(i == 8));
            chk("force_stall", 64'(bus.cpu_stall), 64'(i == 8));
            if (i == 8) begin
                chk("force_addr",  64'(bus.mem_addr),  64'h100);
                chk("force_rdata", 64'(bus.dma_rdata), 64'h0bad_f00d);
                exp_stall++;
            end
            advance();
        end
        bus.dma_req = 1'b0; bus.dma_last = 1'b0;
        settle();
        chk("force_hold_gnt",   64'(bus.dma_gnt),   64'd0);
        chk("force_hold_stall", 64'(bus.cpu_stall), 64'd0);
        chk("force_hold_addr",  64'(bus.mem_addr),  64'h40);
        advance();
        bus.cpu_req = 1'b0;

        // 20-beat burst split by the 16-beat limit
        b = 0;
        bus.dma_we = 1'b1;
        for (int c = 0; c < 24; c++) begin
            bus.dma_req   = (b < 20);
            bus.dma_addr  = 32'h200 + 32'(4 * b);
            bus.dma_wdata = 32'h4000 + 32'(b);
            bus.dma_last  = (b == 19);
            exp_g = ((c >= 1) && (c <= 16)) || ((c >= 19) && (c <= 22));
            if (exp_g) push_wr(32'h200 + 32'(4 * b), 32'h4000 + 32'(b));
            settle();
            chk("burst20_gnt", 64'(bus.dma_gnt), 64'(exp_g));
            advance();
            if (exp_g) b++;
        end
        bus.dma_req = 1'b0; bus.dma_last = 1'b0;

        // DMA write into IO region, error clear, and set-wins-over-clear
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 32'hffff_ff20;
        bus.dma_wdata = 32'heeee; bus.dma_last = 1'b1;
        settle();
        chk("io_lat_gnt", 64'(bus.dma_gnt), 64'd0);
        advance();
        settle();
        chk("io_gnt",  64'(bus.dma_gnt),  64'd1);
        chk("io_we",   64'(bus.mem_we),   64'd0);
        chk("io_addr", 64'(bus.mem_addr), 64'hffff_ff20);
        advance();
        bus.dma_req = 1'b0; bus.dma_last = 1'b0;
        settle();
        chk("io_err_set", 64'(bus.dma_err), 64'd1);
        advance();
        bus.dma_err_clr = 1'b1;
        settle();
        chk("io_err_clr_cycle", 64'(bus.dma_err), 64'd1);
        advance();
        bus.dma_err_clr = 1'b0;
        settle();
        chk("io_err_cleared", 64'(bus.dma_err), 64'd0);
        advance();
        bus.dma_req = 1'b1; bus.dma_last = 1'b1;
        settle();
        advance();
        bus.dma_err_clr = 1'b1;
        settle();
        chk("io2_gnt", 64'(bus.dma_gnt), 64'd1);
        advance();
        bus.dma_err_clr = 1'b0; bus.dma_req = 1'b0; bus.dma_last = 1'b0;
        settle();
        chk("io_set_wins", 64'(bus.dma_err), 64'd1);
        advance();
        bus.dma_err_clr = 1'b1;
        advance();
        bus.dma_err_clr = 1'b0;
        settle();
        chk("io_err_cleared2", 64'(bus.dma_err), 64'd0);
        advance();

        // Reset in the middle of a burst
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 32'h300; bus.dma_wdata = 32'h6000;
        settle();
        chk("mid_lat_gnt", 64'(bus.dma_gnt), 64'd0);
        advance();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h44;
        for (int k = 0; k < 5; k++) begin
            bus.dma_addr = 32'h300 + 32'(4 * k); bus.dma_wdata = 32'h6000 + 32'(k);
            push_wr(32'h300 + 32'(4 * k), 32'h6000 + 32'(k));
            settle();
            chk("mid_gnt",   64'(bus.dma_gnt),   64'd1);
            chk("mid_stall", 64'(bus.cpu_stall), 64'd1);
            exp_stall++;
            advance();
        end
        bus.dma_addr = 32'h314; bus.dma_wdata = 32'h6005;
        #1;
`ifdef DMEM_ARB_PERF_EN
        chk("mid_perf", 64'(bus.perf_stall), 64'(exp_stall));
`else
        chk("mid_perf", 64'(bus.perf_stall), 64'd0);
`endif
        resetn = 1'b0;
        #1;
        chk("rst_mid_gnt",   64'(bus.dma_gnt),    64'd0);
        chk("rst_mid_we",    64'(bus.mem_we),     64'd0);
        chk("rst_mid_stall", 64'(bus.cpu_stall),  64'd0);
        chk("rst_mid_perf",  64'(bus.perf_stall), 64'd0);
        bus.cpu_req = 1'b0; bus.dma_req = 1'b0; bus.dma_we = 1'b0;
        advance();
        advance();
        resetn = 1'b1;
        settle();
        chk("post_rst_gnt", 64'(bus.dma_gnt), 64'd0);
        advance();
        bus.dma_req = 1'b1; bus.dma_addr = 32'h0; bus.dma_last = 1'b1;
        settle();
        chk("restart_lat", 64'(bus.dma_gnt), 64'd0);
        advance();
        settle();
        chk("restart_gnt", 64'(bus.dma_gnt), 64'd1);
        advance();
        bus.dma_req = 1'b0; bus.dma_last = 1'b0;
        settle();
        advance();

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
